// File: rtl/mem_arbiter_if.sv
// Requester, memory and status bundle for mem_arbiter.
// slave is the arbiter's view; master is the requesters/memory environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_ref;
  logic              rw_mem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic [1:0]        grant;
  logic              busy;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  mem_dout,
    output ack0, rdata0, ack1, rdata1,
    output mem_ref, rw_mem, mem_addr, mem_din,
    output grant, busy
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output mem_dout,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_ref, rw_mem, mem_addr, mem_din,
    input  grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and fixed-latency access sequencer
// for the single-ported cpu34 data memory. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               last_q,    last_d;
  logic [1:0]         grant_q,   grant_d;
  logic               ack0_q,    ack0_d;
  logic               ack1_q,    ack1_d;
  logic [DATA_W-1:0]  rdata0_q,  rdata0_d;
  logic [DATA_W-1:0]  rdata1_q,  rdata1_d;
  logic               mem_ref_q, mem_ref_d;
  logic               rw_q,      rw_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [DATA_W-1:0]  din_q,     din_d;
  logic               busy_q,    busy_d;
  logic               pick0;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      grant_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      mem_ref_q <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      mem_ref_q <= mem_ref_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
    end
  end

  // Next state and next register values; outputs are staged one cycle early
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    mem_ref_d = 1'b0;
    rw_d      = rw_q;
    addr_d    = addr_q;
    din_d     = din_q;
    // Requester 0 wins alone, or on a tie when requester 1 went last
    pick0     = bus.req0 && (!bus.req1 || last_q);

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d   = ISSUE;
          mem_ref_d = 1'b1;
          if (pick0) begin
            grant_d = 2'b01;
            last_d  = 1'b0;
            rw_d    = bus.rw0;
            addr_d  = bus.addr0;
            din_d   = bus.wdata0;
          end else begin
            grant_d = 2'b10;
            last_d  = 1'b1;
            rw_d    = bus.rw1;
            addr_d  = bus.addr1;
            din_d   = bus.wdata1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle: memory data is valid now
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
          ack0_d  = grant_q[0];
          ack1_d  = grant_q[1];
          if (!rw_q) begin
            if (grant_q[0]) rdata0_d = bus.mem_dout;
            else            rdata1_d = bus.mem_dout;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.mem_ref  = mem_ref_q;
  assign bus.rw_mem   = rw_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the single-ported data Memory in cpu34. It shares the port between requester 0 (ALU load/store path) and requester 1 (debug/loader port). Each access runs as one mem_ref strobe, then a fixed-latency wait, then a one-cycle ack carrying read data. Ties are resolved round-robin so neither requester can starve the other.

## Interface

Parameters:
- ADDR_W, 32, width of addresses
- DATA_W, 32, width of data
- MEM_LAT, 1, cycles from the mem_ref cycle until mem_dout is valid; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 access request
- rw0  in  1  requester 0 direction: 1 = write, 0 = read
- addr0  in  ADDR_W  requester 0 address
- wdata0  in  DATA_W  requester 0 write data
- ack0  out  1  requester 0 completion pulse
- rdata0  out  DATA_W  requester 0 read data, valid when ack0 = 1
- req1, rw1, addr1, wdata1, ack1, rdata1: same as above, for requester 1
- mem_ref  out  1  memory access strobe, high for one cycle per access
- rw_mem  out  1  memory direction: 1 = write
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data
- grant  out  2  one-hot owner of the current access; 00 when idle
- busy  out  1  high whenever state != IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample req0 and req1.
  - Neither high: stay in IDLE.
  - Exactly one high: grant that requester.
  - Both high: grant the requester not granted last (priority pointer `last`).
  - On grant: latch rw/addr/wdata of the winner, set grant, update `last`, go to ISSUE.
- ISSUE: mem_ref = 1; rw_mem, mem_addr and mem_din drive the latched values. Load the wait counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. At the final WAIT cycle (counter = 1), capture mem_dout into the winner's rdata if the access is a read. Go to DONE.
- DONE: ack of the winner = 1 for exactly one cycle. Go to IDLE; grant returns to 00.
- rdataN changes only on completed reads by requester N. Writes and other-requester accesses leave it unchanged.
- rw_mem, mem_addr and mem_din hold their latched values from ISSUE until the next grant.
- Request values are latched at grant. Changes on, or deassertion of, reqN/rwN/addrN/wdataN after grant are ignored, and the access still completes and acks.
- A requester must drop reqN on the edge where it sees ackN high. If reqN is still high in the following IDLE cycle, it is treated as a new request.
- Reset (rst low, any state, asynchronous):
  - state = IDLE, last = 1 (so requester 0 wins the first tie).
  - Counter = 0.
  - All outputs = 0: ack0, ack1, rdata0, rdata1, mem_ref, rw_mem, mem_addr, mem_din, grant, busy.
  - An in-flight access is abandoned with no ack.

## Timing

- Request visible in IDLE at cycle 0:
  - mem_ref in cycle 1
  - WAIT in cycles 2 .. 1+MEM_LAT
  - ack in cycle 2+MEM_LAT
- Access period is MEM_LAT+3 cycles, including the return to IDLE.
- With MEM_LAT = 1: ack in cycle 3; back-to-back accesses start every 4 cycles.
- mem_ref is never high in two consecutive cycles.
- At most one of ack0/ack1 is high in any cycle.
- grant is one-hot from ISSUE through DONE.
- A request arriving while busy waits, unaffected, until the next IDLE.
- Under continuous contention, grants alternate 0,1,0,1,…

## Test plan

- Reset: hold rst = 0 with random inputs. All outputs read 0. After release, busy = 0 until a request arrives.
- Single read, MEM_LAT = 1: req0 = 1, rw0 = 0, addr0 = 0x10; memory model returns 0xDEADBEEF.
  - Expect mem_ref = 1 and mem_addr = 0x10 in cycle 1.
  - Expect ack0 = 1 and rdata0 = 0xDEADBEEF in cycle 3.
  - Expect ack1 = 0 throughout.
- Write by requester 1: req1 = 1, rw1 = 1, addr1 = 0x20, wdata1 = 0x12345678.
  - Expect rw_mem = 1, mem_din = 0x12345678 and mem_ref for one cycle.
  - Expect ack1 in cycle 3; rdata1 unchanged.
- Contention: req0 and req1 held high together immediately after reset.
  - Grants go 0, then 1, then 0; acks spaced 4 cycles apart.
  - Each requester's rdata matches its own address.
- Reset mid-access: assert rst during WAIT with MEM_LAT = 4.
  - No ack occurs; all outputs are 0.
  - After release, a simultaneous req0/req1 grants requester 0 first.
- Latency sweep: MEM_LAT = 15, single read.
  - Ack arrives exactly 17 cycles after the request.
  - Changing addr0 during WAIT does not alter mem_addr or rdata0.
